// File: rtl/ring_stop_if.sv
// FIFO-side bundle for the ring stop: one instance carries a put (write) port,
// another a get (read) port. Packets are the 70-bit ring slot layout.
interface ring_stop_if;
  logic [69:0] data;
  logic        wrreq;
  logic        full;
  logic [69:0] q;
  logic        rdreq;
  logic        empty;

  // Ring-stop side
  modport put_io (output data, output wrreq, input full);
  modport get_io (input q, output rdreq, input empty);

  // FIFO side
  modport put_fifo (input data, input wrreq, output full);
  modport get_fifo (output q, input rdreq, output empty);
endinterface

// File: rtl/ring_stop.sv
// Ring-side endpoint of one node: consumes unicasts for this node, copies foreign
// broadcasts, retires its own broadcasts and injects staged outbound packets into free slots.
module ring_stop #(
  parameter logic [3:0]  NODE_ID     = 4'd0,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [69:0]            ring_in,
  output logic [69:0]            ring_out,
  ring_stop_if.put_io            inbound_fifo,
  ring_stop_if.get_io            outbound_fifo,
  output logic [COUNT_WIDTH-1:0] consume_stall_count,
  output logic [COUNT_WIDTH-1:0] bcast_miss_count,
  output logic [COUNT_WIDTH-1:0] inject_count
);

  // Slot layout, MSB first; destination node is address[31:28].
  typedef struct packed {
    logic        valid;
    logic        broadcast;
    logic [3:0]  src;
    logic [31:0] address;
    logic [31:0] data;
  } ring_packet_t;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  ring_packet_t pkt_in;
  ring_packet_t stage_q;
  logic [1:0]   state_q, state_d;
  logic         is_consume, is_bcast_other, is_bcast_home;
  logic         slot_free, stage_valid, inject;
  logic         rd_req;

  assign pkt_in = ring_in;

  always_comb begin
    is_consume     = pkt_in.valid && !pkt_in.broadcast && (pkt_in.address[31:28] == NODE_ID);
    is_bcast_other = pkt_in.valid && pkt_in.broadcast && (pkt_in.src != NODE_ID);
    is_bcast_home  = pkt_in.valid && pkt_in.broadcast && (pkt_in.src == NODE_ID);
    // A consumed unicast or a returning home broadcast leaves the slot empty.
    slot_free      = !pkt_in.valid || (is_consume && !inbound_fifo.full) || is_bcast_home;
    stage_valid    = (state_q == HOLD);
    inject         = slot_free && stage_valid;
  end

  always_comb begin
    state_d = state_q;
    rd_req  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!outbound_fifo.empty) begin
          rd_req  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = HOLD;
      HOLD: begin
        if (inject) begin
          if (!outbound_fifo.empty) begin
            rd_req  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are held low for the whole reset assertion, not just after the edge.
  assign inbound_fifo.wrreq  = reset && (is_consume || is_bcast_other) && !inbound_fifo.full;
  assign inbound_fifo.data   = pkt_in;
  assign outbound_fifo.rdreq = reset && rd_req;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q             <= IDLE;
      stage_q             <= '0;
      ring_out            <= '0;
      consume_stall_count <= '0;
      bcast_miss_count    <= '0;
      inject_count        <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH) begin
        stage_q <= outbound_fifo.q;
      end
      if (!slot_free) begin
        ring_out <= pkt_in;
      end else if (inject) begin
        ring_out <= stage_q;
      end else begin
        ring_out <= '0;
      end
      if (inject) begin
        inject_count <= inject_count + COUNT_WIDTH'(1);
      end
      if (is_consume && inbound_fifo.full && (consume_stall_count != '1)) begin
        consume_stall_count <= consume_stall_count + COUNT_WIDTH'(1);
      end
      if (is_bcast_other && inbound_fifo.full && (bcast_miss_count != '1)) begin
        bcast_miss_count <= bcast_miss_count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_ring_stop.sv
// Directed bench for ring_stop at NODE_ID=2 with a small non-showahead outbound FIFO model.
module tb_ring_stop;

  typedef struct packed {
    logic        valid;
    logic        broadcast;
    logic [3:0]  src;
    logic [31:0] address;
    logic [31:0] data;
  } pkt_t;

  logic        clock;
  logic        reset;
  pkt_t        ring_in;
  logic [69:0] ring_out;
  logic [15:0] consume_stall_count;
  logic [15:0] bcast_miss_count;
  logic [15:0] inject_count;

  ring_stop_if inbound_fifo ();
  ring_stop_if outbound_fifo ();

  ring_stop #(
    .NODE_ID     (4'd2),
    .COUNT_WIDTH (16)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .ring_in             (ring_in),
    .ring_out            (ring_out),
    .inbound_fifo        (inbound_fifo),
    .outbound_fifo       (outbound_fifo),
    .consume_stall_count (consume_stall_count),
    .bcast_miss_count    (bcast_miss_count),
    .inject_count        (inject_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  pkt_t ob_q[$];

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic pkt_t mk(input logic bc, input logic [3:0] src, input logic [3:0] dest,
                              input logic [31:0] data);
    pkt_t p;
    p.valid     = 1'b1;
    p.broadcast = bc;
    p.src       = src;
    p.address   = {dest, 28'h0};
    p.data      = data;
    return p;
  endfunction

  // Advance one cycle; the outbound FIFO pops on an edge that saw rdreq.
  task automatic tick();
    logic rd;
    @(negedge clock);
    rd = outbound_fifo.rdreq;
    @(posedge clock);
    #1;
    if (rd && ob_q.size() > 0) outbound_fifo.q = ob_q.pop_front();
    outbound_fifo.empty = (ob_q.size() == 0);
  endtask

  pkt_t uc, bo, bh, fw, p0, p1, p2, q0, q1, q2;
  pkt_t fwd[4];
  logic exp_rd[8];
  pkt_t exp_out[8];
  logic chk_out[8];

  initial begin
    reset               = 1'b0;
    ring_in             = '0;
    inbound_fifo.full   = 1'b0;
    inbound_fifo.q      = '0;
    inbound_fifo.empty  = 1'b1;
    outbound_fifo.full  = 1'b0;
    outbound_fifo.q     = '0;
    outbound_fifo.empty = 1'b1;
    uc = mk(1'b0, 4'd7, 4'd2, 32'h0000_00aa);
    bo = mk(1'b1, 4'd5, 4'd0, 32'h0000_00bb);
    bh = mk(1'b1, 4'd2, 4'd0, 32'h0000_00cc);
    fw = mk(1'b0, 4'd1, 4'd3, 32'h0000_00dd);
    p0 = mk(1'b0, 4'd2, 4'd4, 32'h1000_0000);
    p1 = mk(1'b0, 4'd2, 4'd5, 32'h1000_0001);
    p2 = mk(1'b0, 4'd2, 4'd6, 32'h1000_0002);
    q0 = mk(1'b0, 4'd2, 4'd7, 32'h2000_0000);
    q1 = mk(1'b0, 4'd2, 4'd8, 32'h2000_0001);
    q2 = mk(1'b0, 4'd2, 4'd9, 32'h2000_0002);
    for (int i = 0; i < 4; i++) fwd[i] = mk(1'b0, 4'd1, 4'd3, 32'h3000_0000 + i);

    #2;
    check("rst_ring_out", ring_out, '0);
    check("rst_inject", 70'(inject_count), '0);
    check("rst_wrreq", 70'(inbound_fifo.wrreq), 70'(0));
    tick();
    tick();
    reset = 1'b1;

    // Unicast for this node, inbound has room: consumed, slot freed.
    ring_in = uc;
    #1;
    check("consume_wrreq", 70'(inbound_fifo.wrreq), 70'(1));
    check("consume_data", inbound_fifo.data, uc);
    tick();
    check("consume_free", ring_out, '0);

    // Same unicast with inbound full: recirculates.
    inbound_fifo.full = 1'b1;
    #1;
    check("stall_wrreq", 70'(inbound_fifo.wrreq), 70'(0));
    tick();
    check("stall_fwd", ring_out, uc);
    check("stall_count", 70'(consume_stall_count), 70'(1));

    // Foreign broadcast: copied and forwarded.
    inbound_fifo.full = 1'b0;
    ring_in = bo;
    #1;
    check("bcast_wrreq", 70'(inbound_fifo.wrreq), 70'(1));
    tick();
    check("bcast_fwd", ring_out, bo);
    inbound_fifo.full = 1'b1;
    #1;
    check("bmiss_wrreq", 70'(inbound_fifo.wrreq), 70'(0));
    tick();
    check("bmiss_fwd", ring_out, bo);
    check("bmiss_count", 70'(bcast_miss_count), 70'(1));

    // Own broadcast back home: retired.
    inbound_fifo.full = 1'b0;
    ring_in = bh;
    #1;
    check("bhome_wrreq", 70'(inbound_fifo.wrreq), 70'(0));
    tick();
    check("bhome_free", ring_out, '0);

    // Transit packet.
    ring_in = fw;
    #1;
    check("fwd_wrreq", 70'(inbound_fifo.wrreq), 70'(0));
    tick();
    check("fwd_out", ring_out, fw);

    // Three outbound packets on an idle ring.
    ring_in = '0;
    ob_q.push_back(p0);
    ob_q.push_back(p1);
    ob_q.push_back(p2);
    outbound_fifo.empty = 1'b0;
    exp_rd  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    chk_out = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_out = '{'0, '0, '0, p0, '0, p1, '0, p2};
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("inj_rdreq_%0d", c), 70'(outbound_fifo.rdreq), 70'(exp_rd[c]));
      if (chk_out[c]) check($sformatf("inj_out_%0d", c), ring_out, exp_out[c]);
      if (c < 7) tick();
    end
    check("inj_count3", 70'(inject_count), 70'(3));
    tick();

    // Stage held behind four transit packets; injected into the following gap.
    ob_q.push_back(q0);
    ob_q.push_back(q1);
    ob_q.push_back(q2);
    outbound_fifo.empty = 1'b0;
    #1;
    check("blk_rdreq0", 70'(outbound_fifo.rdreq), 70'(1));
    tick();
    #1;
    check("blk_rdreq1", 70'(outbound_fifo.rdreq), 70'(0));
    tick();
    for (int i = 0; i < 4; i++) begin
      ring_in = fwd[i];
      #1;
      check($sformatf("blk_hold_rdreq_%0d", i), 70'(outbound_fifo.rdreq), 70'(0));
      tick();
      check($sformatf("blk_fwd_%0d", i), ring_out, fwd[i]);
    end
    ring_in = '0;
    #1;
    check("blk_gap_rdreq", 70'(outbound_fifo.rdreq), 70'(1));
    check("blk_count_before", 70'(inject_count), 70'(3));
    tick();
    check("blk_inject", ring_out, q0);
    check("blk_count_after", 70'(inject_count), 70'(4));

    // Stage loaded with q1 but blocked, then reset mid-operation.
    ring_in = fw;
    tick();
    ring_in = uc;
    #1;
    check("pre_rst_wrreq", 70'(inbound_fifo.wrreq), 70'(1));
    reset = 1'b0;
    #1;
    check("mid_rst_ring_out", ring_out, '0);
    check("mid_rst_stall", 70'(consume_stall_count), 70'(0));
    check("mid_rst_miss", 70'(bcast_miss_count), 70'(0));
    check("mid_rst_inject", 70'(inject_count), 70'(0));
    check("mid_rst_wrreq", 70'(inbound_fifo.wrreq), 70'(0));
    check("mid_rst_rdreq", 70'(outbound_fifo.rdreq), 70'(0));
    tick();
    tick();
    reset   = 1'b1;
    ring_in = '0;
    #1;
    check("post_rst_rdreq", 70'(outbound_fifo.rdreq), 70'(1));
    tick();
    tick();
    tick();
    check("post_rst_head", ring_out, q2);
    check("post_rst_count", 70'(inject_count), 70'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
